// File: rtl/sin_cos_cordic.sv
// Iterative sine/cosine of an integer-degree angle: restoring mod-360 reduction,
// quadrant fold into [-90,90], then rotation-mode CORDIC; results scaled by SCALE.
module sin_cos_cordic #(
  parameter int W     = 16,
  parameter int OW    = 16,
  parameter int SCALE = 10000,
  parameter int ITER  = 16,
  parameter int AF    = 16,
  parameter int G     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [W-1:0]         angle,
  output logic                 busy,
  output logic                 done,
  output logic signed [OW-1:0] sin_out,
  output logic signed [OW-1:0] cos_out
);

  localparam int XW   = OW + G + 2;
  localparam int ZW   = AF + 10;
  localparam int MAXC = (W > ITER) ? W : ITER;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    FOLD,
    ROTATE,
    OUTPUT
  } state_e;

  function automatic logic [ITER*ZW-1:0] gen_atan();
    logic [ITER*ZW-1:0] tab;
    real r;
    tab = '0;
    for (int unsigned i = 0; i < ITER; i++) begin
      r = $atan(1.0 / (2.0 ** i)) * 180.0 / 3.14159265358979323846 * (2.0 ** AF);
      tab[i*ZW +: ZW] = ZW'($rtoi(r + 0.5));
    end
    return tab;
  endfunction

  function automatic logic signed [XW-1:0] gen_x0();
    real k;
    k = 1.0;
    for (int unsigned i = 0; i < ITER; i++) begin
      k = k / $sqrt(1.0 + 1.0 / (2.0 ** (2 * i)));
    end
    return XW'($rtoi(k * SCALE * (2.0 ** G) + 0.5));
  endfunction

  localparam logic [ITER*ZW-1:0]     ATAN_PK = gen_atan();
  localparam logic signed [XW-1:0]   X0      = gen_x0();
  localparam logic signed [XW-1:0]   HALF    = XW'(2 ** (G - 1));
  localparam logic signed [XW-1:0]   SAT_HI  = XW'(SCALE);
  localparam logic signed [XW-1:0]   SAT_LO  = XW'(-SCALE);
  localparam logic signed [ZW-1:0]   D180    = ZW'(180);
  localparam logic signed [ZW-1:0]   D360    = ZW'(360);

  function automatic logic signed [OW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI) return OW'(SCALE);
    if (v < SAT_LO) return OW'(-SCALE);
    return OW'(v);
  endfunction

  state_e                state_q, state_d;
  logic [W-1:0]          a_q, a_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]  z_q, z_d;
  logic                  cos_neg_q, cos_neg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic signed [OW-1:0]  sin_q, sin_d, cos_q, cos_d;

  logic [W:0]            red_mod;
  logic [8:0]            a9;
  logic signed [ZW-1:0]  fold_deg;
  logic                  fold_neg;
  logic signed [XW-1:0]  x_sh, y_sh;
  logic signed [ZW-1:0]  atan_i;
  logic signed [XW-1:0]  s_rnd, c_rnd, c_sgn;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    cos_neg_d = cos_neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sin_d     = sin_q;
    cos_d     = cos_q;

    red_mod = (W+1)'(360) << cnt_q;

    a9 = a_q[8:0];
    if (a9 <= 9'd90) begin
      fold_deg = ZW'(a9);
      fold_neg = 1'b0;
    end else if (a9 <= 9'd270) begin
      fold_deg = D180 - ZW'(a9);
      fold_neg = 1'b1;
    end else begin
      fold_deg = ZW'(a9) - D360;
      fold_neg = 1'b0;
    end

    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_i = ATAN_PK[int'(cnt_q)*ZW +: ZW];

    s_rnd = (y_q + HALF) >>> G;
    c_rnd = (x_q + HALF) >>> G;
    c_sgn = cos_neg_q ? -c_rnd : c_rnd;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = angle;
          cnt_d   = CW'(W - 9);
          busy_d  = 1'b1;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        // Restoring remainder: subtract 360*2^k whenever it fits, k descending.
        if ({1'b0, a_q} >= red_mod) a_d = a_q - red_mod[W-1:0];
        if (cnt_q == '0) state_d = FOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FOLD: begin
        z_d       = fold_deg <<< AF;
        cos_neg_d = fold_neg;
        x_d       = X0;
        y_d       = '0;
        cnt_d     = '0;
        state_d   = ROTATE;
      end
      ROTATE: begin
        if (!z_q[ZW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        if (cnt_q == CW'(ITER - 1)) state_d = OUTPUT;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      OUTPUT: begin
        sin_d   = sat(s_rnd);
        cos_d   = sat(c_sgn);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cos_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sin_q     <= '0;
      cos_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      cos_neg_q <= cos_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sin_out = sin_q;
  assign cos_out = cos_q;

endmodule

// File: tb/tb_sin_cos_cordic.sv
// Directed and swept checks of sin_cos_cordic against hand values and a real model.
module tb_sin_cos_cordic;

  localparam int W   = 16;
  localparam int OW  = 16;
  localparam int LAT = 26;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [W-1:0]         angle = '0;
  logic                 busy, done;
  logic signed [OW-1:0] sin_out, cos_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int a;
    int s;
    int c;
    int ts;
    int tc;
  } vec_t;
  vec_t vecs[$];

  sin_cos_cordic #(
    .W(W), .OW(OW), .SCALE(10000), .ITER(16), .AF(16), .G(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .angle(angle),
    .busy(busy), .done(done), .sin_out(sin_out), .cos_out(cos_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    n_cmp++;
    if ((got - exp) > tol || (exp - got) > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int ref_trig(input int a, input bit is_cos);
    real r;
    r = is_cos ? $cos(a * PI / 180.0) : $sin(a * PI / 180.0);
    r = r * 10000.0;
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Starts one computation and waits (bounded) for done; edge count is relative
  // to the edge that sampled start.
  task automatic run_angle(input logic [W-1:0] a, output int s, output int c,
                           output int lat, output int busy_low, output int glitch);
    int ps, pc;
    ps = sin_out;
    pc = cos_out;
    angle = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    angle = ~a;
    lat = 0;
    busy_low = 0;
    glitch = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat >= 1 && busy !== 1'b1) busy_low++;
      if (sin_out != ps || cos_out != pc) glitch++;
      @(negedge clk);
      lat++;
    end
    s = sin_out;
    c = cos_out;
  endtask

  task automatic do_vec(input vec_t v);
    int s, c, lat, bl, gl;
    run_angle(W'(v.a), s, c, lat, bl, gl);
    check($sformatf("lat@%0d", v.a), lat, LAT);
    check($sformatf("busy_gap@%0d", v.a), bl, 0);
    check($sformatf("hold@%0d", v.a), gl, 0);
    check($sformatf("busy_at_done@%0d", v.a), int'(busy), 0);
    check($sformatf("sin@%0d", v.a), s, v.s, v.ts);
    check($sformatf("cos@%0d", v.a), c, v.c, v.tc);
    @(negedge clk);
    check($sformatf("done_pulse@%0d", v.a), int'(done), 0);
  endtask

  initial begin
    int s, c, lat, bl, gl, n, extra;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sin", sin_out, 0);
    check("rst_cos", cos_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{0,     0,      10000,  1, 0});
    vecs.push_back('{30,    5000,   8660,   3, 3});
    vecs.push_back('{90,    10000,  0,      0, 1});
    vecs.push_back('{180,   0,      -10000, 1, 0});
    vecs.push_back('{210,   -5000,  -8660,  3, 3});
    vecs.push_back('{270,   -10000, 0,      0, 1});
    vecs.push_back('{300,   -8660,  5000,   3, 3});
    vecs.push_back('{359,   -175,   9998,   3, 3});
    vecs.push_back('{720,   0,      10000,  1, 0});
    vecs.push_back('{65535, 2588,   9659,   3, 3});
    foreach (vecs[i]) do_vec(vecs[i]);

    // start held high, angle wandering while busy
    angle = W'(30);
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      angle = W'(200 + n);
      @(negedge clk);
      n++;
    end
    check("held_lat1", n, LAT);
    check("held_sin1", sin_out, 5000, 3);
    check("held_cos1", cos_out, 8660, 3);
    angle = W'(60);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      angle = W'(500 + n);
      @(negedge clk);
      n++;
    end
    check("held_lat2", n, LAT);
    check("held_sin2", sin_out, 8660, 3);
    check("held_cos2", cos_out, 5000, 3);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("held_extra_done", extra, 0);

    // reset mid-computation
    angle = W'(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sin", sin_out, 0);
    check("abort_cos", cos_out, 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("abort_no_done", extra, 0);
    do_vec('{45, 7071, 7071, 3, 3});

    // sweep two full turns, back-to-back starts
    for (int a = 0; a < 720; a++) begin
      run_angle(W'(a), s, c, lat, bl, gl);
      check($sformatf("sweep_lat@%0d", a), lat, LAT);
      check($sformatf("sweep_sin@%0d", a), s, ref_trig(a, 1'b0), 3);
      check($sformatf("sweep_cos@%0d", a), c, ref_trig(a, 1'b1), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sin_cos_cordic.md
Name: sin_cos_cordic

Overview:
Iterative, parametrised sine/cosine unit that replaces single-shot combinational Taylor-series evaluation with a multi-cycle CORDIC engine. It accepts an unsigned integer angle in degrees of any magnitude and returns both sin and cos as signed integers scaled by SCALE (default ×10000, the calculator's display fixed-point). It sits in the calculator datapath behind the operation decoder and uses a start/busy/done handshake.

Parameters:
W, 16, angle input width in bits; W ≥ 10
OW, 16, signed output width; must hold ±SCALE
SCALE, 10000, output scale factor (result = round(trig × SCALE))
ITER, 16, CORDIC rotation iterations; 8..24
AF, 16, fractional bits of the internal angle accumulator (degrees × 2^AF)
G, 4, guard fractional bits on the internal x/y datapath

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
angle  in  W  unsigned angle in integer degrees
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when sin_out/cos_out are updated
sin_out  out  OW  signed round(sin(angle°) × SCALE)
cos_out  out  OW  signed round(cos(angle°) × SCALE)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, sin_out=0, cos_out=0; all internal registers cleared. Reset asserted mid-operation aborts the computation; no done pulse follows.
- States: IDLE → REDUCE → FOLD → ROTATE → OUTPUT → IDLE.
- IDLE: on start=1, latch angle and enter REDUCE. start while busy=1 is ignored; angle is not re-sampled.
- REDUCE: W-8 cycles, restoring modulo 360. In step k = W-9 down to 0, if a ≥ 360·2^k then a -= 360·2^k. Result a in [0,359].
- FOLD (1 cycle): a ≤ 90 → z=a, cos_neg=0; 90 < a ≤ 270 → z=180−a, cos_neg=1; a > 270 → z=a−360, cos_neg=0. z is held signed as degrees·2^AF. Sine sign is never flipped.
- ROTATE: ITER cycles, iteration i = 0..ITER−1.
  - d = sign(z).
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan_i.
  - atan_i = round(atan(2^-i)·180/π·2^AF) is an elaboration-time constant table.
  - Initial values: x0 = round(Kn·SCALE·2^G), with Kn = Π 1/√(1+2^-2i) over ITER; y0 = 0.
  - x/y width is OW+G+2 signed; z width is AF+10 signed. Shifts are arithmetic.
- OUTPUT (1 cycle):
  - s = (y + 2^(G−1)) >>> G; c = (x + 2^(G−1)) >>> G; c negated if cos_neg.
  - Saturate s and c to [−SCALE, +SCALE].
  - Register into sin_out/cos_out; done=1 for exactly this cycle, busy drops to 0 in the same cycle. Return to IDLE.
- Latency: start sampled at edge 0 → done high after edge LAT = (W−8) + ITER + 2. Default LAT = 26. Latency is fixed and independent of angle value.
- busy=1 from edge 1 through edge LAT−1. A new start is accepted on the cycle done is high (state is IDLE on that edge's following cycle) or any later IDLE cycle.
- sin_out/cos_out hold their last values until the next done. They are never glitched during computation.
- Accuracy: |error| ≤ 3 LSB versus the ideal rounded value for ITER=16, SCALE=10000. Exact multiples of 90° must return exactly 0 or ±SCALE after saturation; tolerance ±1 LSB is allowed on the zero component.

Test Plan:
- Reset then angle=0, start pulse → done at cycle 26; sin_out=0 (±1), cos_out=10000; busy high cycles 1–25.
- angle=30 → sin_out=5000±3, cos_out=8660±3; angle=90 → sin_out=10000, cos_out=0±1.
- angle=210 → sin_out=−5000±3, cos_out=−8660±3; angle=300 → sin_out=−8660±3, cos_out=5000±3.
- angle=65535 (≡15°) → sin_out=2588±3, cos_out=9659±3; latency still 26.
- start=1 held continuously with angle changing every cycle while busy → only the first angle computed; next start accepted right after done; exactly one done pulse per accepted start.
- rst_n pulsed low at cycle 10 of a computation → outputs 0 immediately, no done pulse; a subsequent start on angle=45 → 7071±3 for both outputs.
- Sweep angle 0..719 versus a real-valued model → every result within ±3 LSB, and results for angle and angle+360 are identical.
